// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the transmit-port arbiter.
//   NUM_PORTS : number of receive ports that may request one transmit port
//               (override with +define+NUM_PORTS=<n>)
//   CREDITS   : depth of the downstream transmit FIFO, which is the reset credit count
//   port_idx_t, port_vec_t, cred_t, state_e : common types
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

package tx_arbiter_pkg;

  localparam int unsigned NUM_REQ = `NUM_PORTS;
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CREDITS = 8;
  localparam int unsigned CRED_W  = $clog2(CREDITS + 1);

  typedef logic [IDX_W-1:0]   port_idx_t;
  typedef logic [NUM_REQ-1:0] port_vec_t;
  typedef logic [CRED_W-1:0]  cred_t;

  typedef enum logic {StRun, StStall} state_e;

endpackage

// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the receive ports and one transmit-port arbiter.
//   req, rx_pop, credit_ret          : driven by the receive side / downstream FIFO
//   grant, grant_valid, grant_idx    : arbitration result (combinational)
//   credits, stalled, cred_err       : registered status
//   stat_grants, stat_stall          : only when TX_ARBITER_STATS_EN is defined
// Modports: master = requesting side, slave = arbiter.
interface tx_arbiter_if;
  import tx_arbiter_pkg::*;

  port_vec_t req;
  port_vec_t rx_pop;
  logic      credit_ret;
  port_vec_t grant;
  logic      grant_valid;
  port_idx_t grant_idx;
  cred_t     credits;
  logic      stalled;
  logic      cred_err;
`ifdef TX_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] stat_grants;
  logic [15:0]           stat_stall;

  modport master (
    output req, rx_pop, credit_ret,
    input  grant, grant_valid, grant_idx, credits, stalled, cred_err, stat_grants, stat_stall
  );
  modport slave (
    input  req, rx_pop, credit_ret,
    output grant, grant_valid, grant_idx, credits, stalled, cred_err, stat_grants, stat_stall
  );
`else
  modport master (
    output req, rx_pop, credit_ret,
    input  grant, grant_valid, grant_idx, credits, stalled, cred_err
  );
  modport slave (
    input  req, rx_pop, credit_ret,
    output grant, grant_valid, grant_idx, credits, stalled, cred_err
  );
`endif
endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first eligible requester at or after i_rr_ptr
// (wrapping), as a one-hot vector plus its index. Purely combinational.
//   i_elig   : eligible requesters
//   i_rr_ptr : highest-priority position this cycle
//   o_grant  : one-hot pick, zero when nothing is eligible
//   o_idx    : index of the pick, zero when nothing is eligible
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] i_elig,
  input  logic [IdxW-1:0]   i_rr_ptr,
  output logic [NumReq-1:0] o_grant,
  output logic [IdxW-1:0]   o_idx
);

  logic            w_found;
  logic [IdxW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_j = IdxW'((32'(i_rr_ptr) + k) % NumReq);
      if (!w_found && i_elig[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter for one transmit port, shared by NUM_REQ receive ports.
// Grants are zero-latency and gated by a downstream credit counter; a requester that
// has been granted stays blocked until it pops its FIFO head, so a multicast head waiting
// on other output ports is not granted twice here.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : tx_arbiter_if.slave (req/rx_pop/credit_ret in, grant/status out)
// Optional: TX_ARBITER_STATS_EN adds saturating per-requester grant and stall counters.
module tx_arbiter
  import tx_arbiter_pkg::*;
(
  input logic         i_clk,
  input logic         i_rst,
  tx_arbiter_if.slave bus
);

  state_e    r_state, w_state_d;
  cred_t     r_credits, w_credits_d;
  port_idx_t r_rr_ptr, w_rr_ptr_d;
  port_vec_t r_served, w_served_d;
  logic      r_cred_err, w_cred_err_d;

  port_vec_t w_elig, w_pick_grant, w_grant;
  port_idx_t w_pick_idx;
  logic      w_can_grant, w_grant_valid;

  assign w_elig = bus.req & ~r_served;

  rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IDX_W)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick_grant),
    .o_idx    (w_pick_idx)
  );

  // rst gates the grant so receive ports never consume one while being reset.
  assign w_can_grant   = (r_state == StRun) && (r_credits != '0) && !i_rst;
  assign w_grant       = w_can_grant ? w_pick_grant : '0;
  assign w_grant_valid = |w_grant;

  assign bus.grant       = w_grant;
  assign bus.grant_valid = w_grant_valid;
  assign bus.grant_idx   = w_grant_valid ? w_pick_idx : '0;
  assign bus.credits     = r_credits;
  assign bus.stalled     = (r_state == StStall);
  assign bus.cred_err    = r_cred_err;

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
    if (w_grant_valid) begin
      w_rr_ptr_d = port_idx_t'((32'(w_pick_idx) + 32'd1) % NUM_REQ);
    end
    // Pop wins: a completing grant and its pop land in the same cycle.
    w_served_d = (r_served | w_grant) & ~bus.rx_pop;
  end

  always_comb begin
    w_credits_d  = r_credits;
    w_cred_err_d = r_cred_err;
    if (bus.credit_ret && !w_grant_valid) begin
      if (r_credits == cred_t'(CREDITS)) begin
        w_cred_err_d = 1'b1;
      end else begin
        w_credits_d = r_credits + cred_t'(1);
      end
    end else if (!bus.credit_ret && w_grant_valid) begin
      w_credits_d = r_credits - cred_t'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (w_credits_d == '0) w_state_d = StStall;
      StStall: if (w_credits_d != '0) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StRun;
      r_credits  <= cred_t'(CREDITS);
      r_rr_ptr   <= '0;
      r_served   <= '0;
      r_cred_err <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_credits  <= w_credits_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_served   <= w_served_d;
      r_cred_err <= w_cred_err_d;
    end
  end

`ifdef TX_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stat_grants;
  logic [15:0]              r_stat_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_grants <= '0;
      r_stat_stall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && (r_stat_grants[i] != 16'hFFFF)) begin
          r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
        end
      end
      if ((r_state == StStall) && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign bus.stat_grants = r_stat_grants;
  assign bus.stat_stall  = r_stat_stall;
`endif

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- One instance per output port. Shares that port's single transmit path among the NUM_PORTS receive ports using round-robin.
- Issues a one-hot grant that the receive-port FSMs consume in the same cycle. Those FSMs hold a multicast head in their FIFO until every target port has granted it.
- Tracks free space in the downstream transmit FIFO with a credit counter, and suppresses duplicate grants to a multicast head that this port has already served.

Parameters:
- NUM_REQ, `NUM_PORTS (4): number of requesting receive ports.
- CREDITS, 8: depth of the downstream transmit FIFO, which is the initial credit count.
- CRED_W, $clog2(CREDITS+1): width of the credit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  req[i] = rx port i pkt_valid AND that packet's target bit for this output port.
- rx_pop  in  NUM_REQ  rx port i popped its FIFO head this cycle.
- credit_ret  in  1  downstream transmit FIFO popped one entry; returns one credit.
- grant  out  NUM_REQ  one-hot or zero; combinational from req and registered state.
- grant_valid  out  1  equals OR of grant.
- grant_idx  out  $clog2(NUM_REQ)  index of the granted requester; 0 when grant_valid=0.
- credits  out  CRED_W  current credit count, registered.
- stalled  out  1  high when FSM is in ST_STALL, registered.
- cred_err  out  1  sticky overflow error.

Behaviour:
- Reset (rst=1 at posedge):
  - credits=CREDITS, rr_ptr=0, served=0, state=ST_RUN, cred_err=0.
  - grant is 0 during any cycle where rst=1.
- Eligibility: elig[i] = req[i] & ~served[i].
- Grant:
  - Zero latency, same cycle as req.
  - Granted requester = first i with elig[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Granted only when state==ST_RUN and credits!=0. Otherwise grant=0.
- rr_ptr update: on grant to i, next rr_ptr = (i+1) mod NUM_REQ. Unchanged without a grant.
- served[i] handling:
  - Set on a grant to i.
  - Cleared on rx_pop[i]. Clear wins over set in the same cycle, because a completing grant and its pop coincide.
  - Purpose: blocks regranting a multicast head that is still waiting on other ports.
- Credits:
  - Next credits = credits − grant_valid + credit_ret.
  - Grant and credit_ret in the same cycle leave the count unchanged.
  - credit_ret with credits==CREDITS and no grant: count holds at CREDITS and cred_err sets. cred_err clears only on rst.
- FSM (2 states):
  - ST_RUN → ST_STALL when next credits==0.
  - ST_STALL → ST_RUN when next credits!=0. A credit_ret in ST_STALL therefore allows a grant on the following cycle.
  - stalled = (state==ST_STALL).
- Boundaries:
  - req with no eligible bits: no grant, no pointer move.
  - The last credit may be granted. Once credits reach 0, stalled asserts on the next cycle.
  - Requests held through a stall are granted in round-robin order after the stall, with no starvation.
  - rst mid-multicast: served clears. The rx ports are reset on the same event by system convention.

Optional Feature:
- Macro: TX_ARBITER_STATS_EN.
- When defined:
  - Adds output stat_grants (NUM_REQ*16): per-requester saturating 16-bit grant counters.
  - Adds output stat_stall (16): saturating count of cycles spent in ST_STALL.
  - All counters clear on rst.
- When undefined: these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- switch_defs package:
  - `NUM_PORTS
  - typedef port_idx_t = logic [$clog2(`NUM_PORTS)-1:0]
  - typedef port_vec_t = logic [`NUM_PORTS-1:0]
  - CREDITS default constant
- Sub-module rr_pick: pure combinational rotate-priority picker. Inputs elig and rr_ptr; outputs one-hot grant and index. Reusable by other arbiters.

Test Plan:
- Reset then req=4'b1111 held, rx_pop mirroring grant, credit_ret=1 every cycle → grants cycle 0001, 0010, 0100, 1000, 0001; credits stay 8.
- Multicast: req[2]=1 held, rx_pop[2] low for 5 cycles → exactly one grant to 2, then no grants. Assert rx_pop[2] → served[2] clears and req[2] is granted again on the next cycle.
- Credit exhaustion: req=4'b0001 always, rx_pop each grant, credit_ret=0 → 8 grants, credits=0, stalled=1, no further grants. One credit_ret pulse → exactly one more grant.
- Simultaneous: grant and credit_ret in the same cycle at credits=3 → credits remain 3.
- Overflow: credits=8, credit_ret=1, no req → credits=8, cred_err=1, still set 10 cycles later; rst clears it.
- rst asserted mid-stream with req=4'b1010, rr_ptr=3 → next cycle after rst deasserts, grant=4'b0010, credits=8.
